// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one simple_uart transmit channel among
// NUM_REQ byte sources. Each grant sends exactly one byte. A source can hold
// req_lock to keep the channel across several bytes so that a message is not
// interleaved with bytes from other sources. If the UART fails to raise busy
// within START_TIMEOUT cycles after a start pulse, the arbiter gives up on
// that byte and raises start_error.

module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_transmit,
  output logic [7:0]           tx_byte,
  input  logic                 tx_busy,
  output logic                 start_error
);

  // Index width for requester numbers; NUM_REQ is at least 2.
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // The timeout counter must be able to hold START_TIMEOUT itself.
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(START_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] lock_owner;
  logic             lock_held;
  logic [CNT_W-1:0] start_cnt;

  // Arbitration terms, all derived from the current inputs and lock state.
  logic [NUM_REQ-1:0] owner_mask;
  logic               lock_keep;
  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W:0]     rr_sum;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_mask;
  logic [7:0]         win_byte;
  logic               win_lock;

  // Restrict eligibility to the lock owner while it still asks for the lock.
  // Once the owner drops req_lock, everybody is eligible in that same cycle.
  always_comb begin
    owner_mask = NUM_REQ'(1) << lock_owner;
    lock_keep  = lock_held && |(req_lock & owner_mask);
    eligible   = lock_keep ? (req_valid & owner_mask) : req_valid;
  end

  // Circular search for the first eligible requester after last_grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last_grant} + (IDX_W + 1)'(k);
      if (rr_sum >= NUM_REQ_W) begin
        rr_sum = rr_sum - NUM_REQ_W;
      end
      if (!win_found && |(eligible & (NUM_REQ'(1) << rr_sum[IDX_W-1:0]))) begin
        win_found = 1'b1;
        win_idx   = rr_sum[IDX_W-1:0];
      end
    end
  end

  // Winner-dependent data: one-hot mask, its byte lane and its lock request.
  always_comb begin
    win_mask = NUM_REQ'(1) << win_idx;
    win_byte = 8'(req_data >> {win_idx, 3'b000});
    win_lock = |(req_lock & win_mask);
  end

  // Channel FSM; every output is registered here so pulses are glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= LAST_IDX;
      lock_owner  <= '0;
      lock_held   <= 1'b0;
      start_cnt   <= '0;
      grant       <= '0;
      req_ack     <= '0;
      tx_transmit <= 1'b0;
      tx_byte     <= 8'h00;
      start_error <= 1'b0;
    end else begin
      req_ack     <= '0;
      tx_transmit <= 1'b0;
      start_error <= 1'b0;
      unique case (state)
        IDLE: begin
          // Owner let go of the lock: drop ownership; a win below overrides.
          if (lock_held && !lock_keep) begin
            lock_held <= 1'b0;
            grant     <= '0;
          end
          if (!tx_busy && win_found) begin
            tx_byte     <= win_byte;
            tx_transmit <= 1'b1;
            req_ack     <= win_mask;
            grant       <= win_mask;
            last_grant  <= win_idx;
            lock_held   <= win_lock;
            lock_owner  <= win_idx;
            start_cnt   <= '0;
            state       <= WAIT_START;
          end
        end
        WAIT_START: begin
          // Busy wins over an expiring counter in the same cycle.
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (start_cnt == CNT_LAST) begin
            // The byte was already acked, so it is dropped rather than resent.
            start_error <= 1'b1;
            start_cnt   <= CNT_MAX;
            lock_held   <= 1'b0;
            grant       <= '0;
            state       <= IDLE;
          end else if (start_cnt < CNT_MAX) begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          // A held lock keeps the owner visible on grant between bytes.
          if (!tx_busy) begin
            if (!lock_held) begin
              grant <= '0;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two queued requesters, a simple UART busy model
// and a scoreboard monitor comparing every transmitted byte against the
// expected sequence.

module tb_uart_tx_arbiter;

  localparam int NREQ     = 2;
  localparam int TIMEOUT  = 4;
  localparam int BUSY_CYC = 20;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   grant;
  logic              tx_transmit;
  logic [7:0]        tx_byte;
  logic              tx_busy;
  logic              start_error;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .START_TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .req_ack     (req_ack),
    .grant       (grant),
    .tx_transmit (tx_transmit),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy),
    .start_error (start_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Requester queues: bit 8 = lock request, bits 7:0 = byte.
  logic [8:0]  rq0[$];
  logic [8:0]  rq1[$];
  // Expected transmissions: bits 15:8 = requester index, bits 7:0 = byte.
  logic [15:0] exp_q[$];

  int n_chk    = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int last_gap = -1;
  bit uart_en  = 1'b1;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(int idx, logic [7:0] b);
    exp_q.push_back({8'(idx), b});
  endfunction

  // Requester and UART driver: acts on the falling edge, away from sampling.
  initial begin
    logic [8:0] h;
    int         bcnt;
    bit         pend;
    req_valid = '0;
    req_data  = '0;
    req_lock  = '0;
    tx_busy   = 1'b0;
    bcnt      = 0;
    pend      = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        tx_busy = 1'b0;
        bcnt    = 0;
        pend    = 1'b0;
      end else begin
        if (req_ack[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (req_ack[1] && rq1.size() > 0) void'(rq1.pop_front());
        if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) tx_busy = 1'b0;
        end
        if (pend) begin
          pend    = 1'b0;
          tx_busy = 1'b1;
          bcnt    = BUSY_CYC;
        end
        if (tx_transmit && uart_en) pend = 1'b1;
      end
      if (!reset && rq0.size() > 0) begin
        h = rq0[0];
        req_valid[0]   = 1'b1;
        req_data[7:0]  = h[7:0];
        req_lock[0]    = h[8];
      end else begin
        req_valid[0] = 1'b0;
        req_lock[0]  = 1'b0;
      end
      if (!reset && rq1.size() > 0) begin
        h = rq1[0];
        req_valid[1]   = 1'b1;
        req_data[15:8] = h[7:0];
        req_lock[1]    = h[8];
      end else begin
        req_valid[1] = 1'b0;
        req_lock[1]  = 1'b0;
      end
    end
  end

  // Scoreboard monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [15:0] e;
    logic [7:0]  last_exp_byte;
    bit prev_tx, prev_err, prev_busy, tracking;
    int gap, since;
    prev_tx = 0; prev_err = 0; prev_busy = 0; tracking = 0;
    gap = 0; since = 0; last_exp_byte = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        prev_tx = 0; prev_err = 0; prev_busy = 0; tracking = 0; since = 0;
        continue;
      end
      since++;
      if (prev_busy && !tx_busy) begin
        tracking = 1;
        gap      = 0;
      end else if (tracking) begin
        gap++;
      end
      if (prev_tx) begin
        check("tx_pulse_width", int'(tx_transmit), 0);
        check("ack_pulse_width", int'(req_ack), 0);
        check("tx_byte_hold", int'(tx_byte), int'(last_exp_byte));
      end
      if (prev_err) check("err_pulse_width", int'(start_error), 0);
      if (tx_transmit) begin
        check("tx_while_busy", int'(tx_busy), 0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_tx: got byte %0h, expected no transmission", tx_byte);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", int'(tx_byte), int'(e[7:0]));
          check("req_ack", int'(req_ack), 1 << e[15:8]);
          check("grant", int'(grant), 1 << e[15:8]);
          last_exp_byte = e[7:0];
        end
        last_gap = tracking ? gap : -1;
        tracking = 0;
        since    = 0;
      end
      if (start_error) begin
        err_cnt++;
        check("err_delay", since, TIMEOUT);
      end
      prev_tx   = tx_transmit;
      prev_err  = start_error;
      prev_busy = tx_busy;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    rq0.delete();
    rq1.delete();
    exp_q.delete();
    err_cnt  = 0;
    last_gap = -1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, int'(n < budget), 1);
    repeat (40) @(negedge clock);
  endtask

  initial begin
    int n;
    reset   = 1'b0;
    uart_en = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("rst_req_ack", int'(req_ack), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_tx_transmit", int'(tx_transmit), 0);
    check("rst_tx_byte", int'(tx_byte), 0);
    check("rst_start_error", int'(start_error), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Single requester, two bytes back to back.
    do_reset();
    rq0.push_back({1'b0, 8'h41});
    rq0.push_back({1'b0, 8'h42});
    push_exp(0, 8'h41);
    push_exp(0, 8'h42);
    wait_drain("t1_drain", 1000);
    check("t1_gap", last_gap, 1);
    check("t1_grant_idle", int'(grant), 0);

    // Fairness: both continuously valid.
    do_reset();
    rq0.push_back({1'b0, 8'h11});
    rq0.push_back({1'b0, 8'h11});
    rq1.push_back({1'b0, 8'h22});
    rq1.push_back({1'b0, 8'h22});
    push_exp(0, 8'h11);
    push_exp(1, 8'h22);
    push_exp(0, 8'h11);
    push_exp(1, 8'h22);
    wait_drain("t2_drain", 2000);

    // Lock: requester 1 sends three locked bytes, requester 0 waits.
    do_reset();
    rq0.push_back({1'b0, 8'h55});
    rq0.push_back({1'b0, 8'h55});
    rq1.push_back({1'b1, 8'hA0});
    rq1.push_back({1'b1, 8'hA1});
    rq1.push_back({1'b1, 8'hA2});
    push_exp(0, 8'h55);
    push_exp(1, 8'hA0);
    push_exp(1, 8'hA1);
    push_exp(1, 8'hA2);
    push_exp(0, 8'h55);
    wait_drain("t3_drain", 3000);
    check("t3_err_cnt", err_cnt, 0);

    // Idle lock release: owner drops valid and lock together.
    do_reset();
    rq0.push_back({1'b1, 8'hB0});
    rq1.push_back({1'b0, 8'h7E});
    push_exp(0, 8'hB0);
    push_exp(1, 8'h7E);
    wait_drain("t6_drain", 1000);
    check("t6_gap", last_gap, 1);
    check("t6_grant_idle", int'(grant), 0);

    // Start timeout: busy never rises.
    do_reset();
    uart_en = 1'b0;
    rq0.push_back({1'b0, 8'h31});
    rq0.push_back({1'b0, 8'h32});
    push_exp(0, 8'h31);
    push_exp(0, 8'h32);
    wait_drain("t4_drain", 500);
    check("t4_err_cnt", err_cnt, 2);
    check("t4_grant_idle", int'(grant), 0);
    uart_en = 1'b1;

    // Reset in the middle of a frame.
    do_reset();
    rq0.push_back({1'b0, 8'h66});
    push_exp(0, 8'h66);
    n = 0;
    while (!tx_busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("t5_busy_seen", int'(n < 200), 1);
    repeat (3) @(negedge clock);
    check("t5_grant_before", int'(grant), 1);
    check("t5_byte_before", int'(tx_byte), 8'h66);
    #1 reset = 1'b1;
    #1;
    check("t5_req_ack", int'(req_ack), 0);
    check("t5_grant", int'(grant), 0);
    check("t5_tx_transmit", int'(tx_transmit), 0);
    check("t5_tx_byte", int'(tx_byte), 0);
    check("t5_start_error", int'(start_error), 0);
    rq0.delete();
    rq1.delete();
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rq0.push_back({1'b0, 8'h11});
    rq1.push_back({1'b0, 8'h22});
    push_exp(0, 8'h11);
    push_exp(1, 8'h22);
    wait_drain("t5_drain", 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
